// File: rtl/sd_host_pkg.sv
// ============================================================================
// Module   : sd_host_pkg
// Purpose  : Shared sequencer state encoding and command-frame marker bits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_REQ  = 3'd1,
    ST_SEND_REL  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RESP_ACK  = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_e;

  // Leading bits of every command frame: start bit then transmission bit.
  localparam logic CMD_START_BIT = 1'b0;
  localparam logic CMD_TX_BIT    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cmd_timeout_counter.sv
// ============================================================================
// Module   : cmd_timeout_counter
// Purpose  : Saturating response-window counter; expired on count TIMEOUT-1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Holds at LAST instead of wrapping so a late response still sees expiry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// ============================================================================
// Module   : cmd_sequencer
// Purpose  : Command issue / response handshake sequencer with response
//            timeout; define CMD_SEQ_RETRY_EN to resend on timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_sequencer
  import sd_host_pkg::*;
#(
  parameter int ARG_W     = 32,
  parameter int CMD_W     = 40,
  parameter int RESP_W    = 40,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        cmd_index,
  input  logic [ARG_W-1:0]  argument_reg,
  input  logic              resp_expected,
  input  logic              ack_in,
  input  logic              req_in,
  input  logic [RESP_W-1:0] cmd_in,
  output logic              req_out,
  output logic [CMD_W-1:0]  cmd_out,
  output logic              ack_out,
  output logic [RESP_W-1:0] resp_out,
  output logic              done,
  output logic              timeout_err,
  output logic              idle_out
);

  seq_state_e state;
  seq_state_e next_state;

  logic resp_exp_lat;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;
  logic start_ok;
  logic resp_hit;
  logic timeout_hit;
  logic retry_left;

  assign start_ok    = start && (state == ST_IDLE);
  assign resp_hit    = (state == ST_WAIT_RESP) && req_in;
  // A response on the final window cycle takes priority over the timeout.
  assign timeout_hit = (state == ST_WAIT_RESP) && !req_in && timer_expired;

  cmd_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

`ifdef CMD_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0] retry_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (start_ok) begin
      retry_cnt <= '0;
    end else if (timeout_hit && retry_left) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_left = (retry_cnt < RETRY_W'(MAX_RETRY));
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
  assign retry_left       = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_SEND_REQ;
      end
      ST_SEND_REQ: begin
        if (ack_in) next_state = ST_SEND_REL;
      end
      ST_SEND_REL: begin
        if (!ack_in) next_state = resp_exp_lat ? ST_WAIT_RESP : ST_FINISH;
      end
      ST_WAIT_RESP: begin
        if (req_in) begin
          next_state = ST_RESP_ACK;
        end else if (timer_expired) begin
          next_state = retry_left ? ST_SEND_REQ : ST_FINISH;
        end
      end
      ST_RESP_ACK: begin
        if (!req_in) next_state = ST_FINISH;
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_out     = 1'b0;
    ack_out     = 1'b0;
    done        = 1'b0;
    idle_out    = 1'b0;
    timer_en    = 1'b0;
    timer_clear = 1'b1;
    case (state)
      ST_IDLE:      idle_out = 1'b1;
      ST_SEND_REQ:  req_out  = 1'b1;
      ST_WAIT_RESP: begin
        timer_en    = 1'b1;
        timer_clear = 1'b0;
      end
      ST_RESP_ACK:  ack_out  = 1'b1;
      ST_FINISH:    done     = 1'b1;
      default:      idle_out = 1'b0;
    endcase
  end

  // Frame is captured once per accepted start, so retries resend it unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_out      <= '0;
      resp_exp_lat <= 1'b0;
      resp_out     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (start_ok) begin
        cmd_out      <= CMD_W'({CMD_START_BIT, CMD_TX_BIT, cmd_index, argument_reg});
        resp_exp_lat <= resp_expected;
        timeout_err  <= 1'b0;
      end
      if (resp_hit) begin
        resp_out <= cmd_in;
      end
      if (timeout_hit && !retry_left) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// ============================================================================
// Module   : tb_cmd_sequencer
// Purpose  : Randomized self-checking bench; the bench plays the serial host.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmd_sequencer;

  localparam int ARG_W     = 32;
  localparam int CMD_W     = 40;
  localparam int RESP_W    = 40;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;
`ifdef CMD_SEQ_RETRY_EN
  localparam int MAX_ATT   = 1 + MAX_RETRY;
`else
  localparam int MAX_ATT   = 1;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [5:0]        cmd_index = '0;
  logic [ARG_W-1:0]  argument_reg = '0;
  logic              resp_expected = 1'b0;
  logic              ack_in = 1'b0;
  logic              req_in = 1'b0;
  logic [RESP_W-1:0] cmd_in = '0;
  logic              req_out;
  logic [CMD_W-1:0]  cmd_out;
  logic              ack_out;
  logic [RESP_W-1:0] resp_out;
  logic              done;
  logic              timeout_err;
  logic              idle_out;

  cmd_sequencer #(
    .ARG_W     (ARG_W),
    .CMD_W     (CMD_W),
    .RESP_W    (RESP_W),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .cmd_index     (cmd_index),
    .argument_reg  (argument_reg),
    .resp_expected (resp_expected),
    .ack_in        (ack_in),
    .req_in        (req_in),
    .cmd_in        (cmd_in),
    .req_out       (req_out),
    .cmd_out       (cmd_out),
    .ack_out       (ack_out),
    .resp_out      (resp_out),
    .done          (done),
    .timeout_err   (timeout_err),
    .idle_out      (idle_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  int   req_rise = 0;
  int   ack_cnt  = 0;
  logic req_prev = 1'b0;
  int   rdel[4];

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (req_out && !req_prev) req_rise++;
    if (ack_out) ack_cnt++;
    req_prev = req_out;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return req_out;
      1:       return ack_out;
      default: return done;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic lvl, input int budget,
                            input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (pick(sel) == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " wait expired"}, 64'd0, 64'd1);
  endtask

  task automatic recover;
    #2 reset = 1'b1;
    ack_in = 1'b0;
    req_in = 1'b0;
    start  = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Host side of one command; rdel[i] = response delay for attempt i,
  // where a delay above TIMEOUT means the host never answers that attempt.
  task automatic run_cmd(input logic [5:0] idx, input logic [ARG_W-1:0] arg,
                         input logic rexp, input int a, input int b,
                         input logic [RESP_W-1:0] data, input bit poke);
    logic [CMD_W-1:0] frame;
    bit   accepted;
    bit   ok;
    bit   hung;
    int   n_att;
    int   cyc0;
    int   cyc_done;
    logic exp_err;

    frame    = {2'b01, idx, arg};
    accepted = 1'b0;
    hung     = 1'b0;
    n_att    = rexp ? MAX_ATT : 1;
    if (rexp) begin
      for (int i = MAX_ATT - 1; i >= 0; i--) begin
        if (rdel[i] <= TIMEOUT) begin
          accepted = 1'b1;
          n_att    = i + 1;
        end
      end
    end
    exp_err = rexp && !accepted;

    done_cnt = 0;
    req_rise = 0;
    ack_cnt  = 0;
    @(posedge clock);
    #1;
    start         = 1'b1;
    cmd_index     = idx;
    argument_reg  = arg;
    resp_expected = rexp;
    cyc0          = cyc;
    @(posedge clock);
    #1;
    start         = 1'b0;
    cmd_index     = 6'($urandom);
    argument_reg  = ARG_W'($urandom);
    resp_expected = 1'($urandom);

    for (int att = 0; att < n_att; att++) begin
      wait_level(0, 1'b1, TIMEOUT + 40, "req_out rise", ok);
      if (!ok) begin hung = 1'b1; break; end
      check("cmd_out frame", 64'(cmd_out), 64'(frame));
      if (att == 0) check("timeout_err cleared by start", 64'(timeout_err), 64'd0);
      if (poke && a > 0) begin
        start     = 1'b1;
        cmd_index = ~idx;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (a - 1) @(posedge clock);
      end else begin
        repeat (a) @(posedge clock);
      end
      #1 ack_in = 1'b1;
      wait_level(0, 1'b0, 20, "req_out release", ok);
      if (!ok) begin hung = 1'b1; break; end
      repeat (b) @(posedge clock);
      #1 ack_in = 1'b0;
      if (rexp && rdel[att] <= TIMEOUT) begin
        repeat (rdel[att]) @(posedge clock);
        #1;
        req_in = 1'b1;
        cmd_in = data;
        wait_level(1, 1'b1, 8, "ack_out rise", ok);
        if (!ok) begin hung = 1'b1; break; end
        @(posedge clock);
        #1;
        req_in = 1'b0;
        cmd_in = RESP_W'({$urandom, $urandom});
      end
    end

    if (!hung) begin
      wait_level(2, 1'b1, TIMEOUT + 40, "done", ok);
      if (!ok) hung = 1'b1;
    end
    cyc_done = cyc;
    if (!hung && (!rexp || (MAX_ATT == 1 && !accepted)))
      check("done latency", 64'(cyc_done - cyc0), rexp ? 64'(3 + a + b + TIMEOUT) : 64'(3 + a + b));
    repeat (2) @(negedge clock);
    check("done pulses", 64'(done_cnt), 64'd1);
    check("req_out assertions", 64'(req_rise), 64'(n_att));
    check("ack_out seen", 64'(ack_cnt != 0), 64'(accepted));
    check("timeout_err", 64'(timeout_err), 64'(exp_err));
    if (accepted) check("resp_out", 64'(resp_out), 64'(data));
    check("cmd_out held", 64'(cmd_out), 64'(frame));
    check("idle_out", 64'(idle_out), 64'd1);
    if (hung) recover();
  endtask

  task automatic check_reset_vals(input string where);
    check({where, " req_out"},     64'(req_out),     64'd0);
    check({where, " ack_out"},     64'(ack_out),     64'd0);
    check({where, " cmd_out"},     64'(cmd_out),     64'd0);
    check({where, " resp_out"},    64'(resp_out),    64'd0);
    check({where, " done"},        64'(done),        64'd0);
    check({where, " timeout_err"}, 64'(timeout_err), 64'd0);
    check({where, " idle_out"},    64'(idle_out),    64'd1);
  endtask

  // Reset lands between clock edges, so the outputs must clear without one.
  task automatic reset_mid(input bit in_resp_ack);
    bit ok;
    @(posedge clock);
    #1;
    start         = 1'b1;
    cmd_index     = 6'd17;
    argument_reg  = 32'hCAFE_0001;
    resp_expected = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_level(0, 1'b1, 10, "rst req_out", ok);
    if (in_resp_ack && ok) begin
      #1 ack_in = 1'b1;
      wait_level(0, 1'b0, 10, "rst req_out release", ok);
      #1 ack_in = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      req_in = 1'b1;
      cmd_in = 40'hA5_1234_5678;
      wait_level(1, 1'b1, 10, "rst ack_out", ok);
    end
    #2 reset = 1'b1;
    #1 check_reset_vals(in_resp_ack ? "reset in RESP_ACK" : "reset in SEND_REQ");
    ack_in = 1'b0;
    req_in = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 check_reset_vals("power-on reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // Index 8 / arg 0x1AA, ack after 2 cycles, response after 10.
    for (int i = 0; i < 4; i++) rdel[i] = 10;
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 2, 1, 40'h08_0000_01AA, 1'b0);
    // No response expected.
    run_cmd(6'd0, 32'h1234_5678, 1'b0, 1, 0, '0, 1'b1);
    // Host never answers.
    for (int i = 0; i < 4; i++) rdel[i] = TIMEOUT + 5;
    run_cmd(6'd5, 32'hDEAD_BEEF, 1'b1, 1, 1, '0, 1'b1);
    // Response arrives on the last window cycle.
    rdel[0] = TIMEOUT;
    run_cmd(6'd12, 32'h0000_0F0F, 1'b1, 0, 0, 40'h11_2233_4455, 1'b0);
    // One cycle too late on the first attempt, prompt on any retry.
    rdel[0] = TIMEOUT + 1;
    for (int i = 1; i < 4; i++) rdel[i] = 3;
    run_cmd(6'd41, 32'h8000_0001, 1'b1, 2, 2, 40'h77_0000_0001, 1'b0);

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) rdel[i] = int'($urandom_range(1, TIMEOUT + 4));
      run_cmd(6'($urandom), ARG_W'($urandom), 1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              RESP_W'({$urandom, $urandom}), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
